// File: rtl/clk_div_prog.sv
// clk_div_prog: free-running divider, glitch-free fast/slow CPU clock and NCH programmable divider channels
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       asynchronous active-low reset
//   sel_slow  1 selects the slow CPU clock (asynchronous board switch)
//   en        channel enable, gates every channel counter (not clkdiv)
//   div_load  per-channel shadow divisor write strobe
//   div_val   divisor data, channel i uses [i*DIV_W +: DIV_W]
//   clkdiv    free-running counter
//   clk_cpu   registered CPU clock, switches only at a shared low phase
//   ch_out    near-50% divided waveform per channel (data/enable use only)
//   ch_tick   one-cycle enable pulse at the last cycle of each channel period
module clk_div_prog #(
    parameter int              CNT_W    = 32,
    parameter int              FAST_BIT = 2,
    parameter int              SLOW_BIT = 16,
    parameter int              NCH      = 2,
    parameter int              DIV_W    = 16,
    parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(50)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_slow,
    input  logic                 en,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH*DIV_W-1:0] div_val,
    output logic [CNT_W-1:0]     clkdiv,
    output logic                 clk_cpu,
    output logic [NCH-1:0]       ch_out,
    output logic [NCH-1:0]       ch_tick
);
    logic [CNT_W-1:0] r_clkdiv;
    logic [CNT_W-1:0] w_clkdiv_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_active_sel;
    logic             r_clk_cpu;
    logic             w_boundary;

    assign w_clkdiv_nxt = r_clkdiv + CNT_W'(1);
    // Last cycle before both the fast and slow bits fall to 0 together.
    assign w_boundary   = &r_clkdiv[SLOW_BIT:0];
    assign clkdiv       = r_clkdiv;
    assign clk_cpu      = r_clk_cpu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clkdiv     <= '0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_active_sel <= 1'b0;
            r_clk_cpu    <= 1'b0;
        end else begin
            r_clkdiv  <= w_clkdiv_nxt;
            r_sync1   <= sel_slow;
            r_sync2   <= r_sync1;
            if (w_boundary)
                r_active_sel <= r_sync2;
            // Uses the pre-boundary select; at the boundary both candidate bits are 0.
            r_clk_cpu <= r_active_sel ? w_clkdiv_nxt[SLOW_BIT] : w_clkdiv_nxt[FAST_BIT];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : gen_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_shadow;
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] w_val;
        logic [DIV_W-1:0] w_new;
        logic [DIV_W-1:0] w_half;
        logic             w_run;
        logic             w_tick;

        assign w_val  = div_val[g*DIV_W +: DIV_W];
        assign w_run  = r_div != '0;
        assign w_tick = en & w_run & (r_cnt == r_div - DIV_W'(1));
        // A load coinciding with the transfer takes priority over the old shadow.
        assign w_new  = div_load[g] ? w_val : r_shadow;
        // ceil(D/2) without needing an extra bit.
        assign w_half = (r_div >> 1) + DIV_W'(r_div[0]);
        assign ch_tick[g] = w_tick;
        assign ch_out[g]  = w_run & (r_cnt < w_half);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt    <= '0;
                r_shadow <= DEF_DIV;
                r_div    <= DEF_DIV;
            end else begin
                if (div_load[g])
                    r_shadow <= w_val;
                // A stopped channel picks up a new divisor straight away.
                if (!w_run || w_tick) begin
                    r_div <= w_new;
                    r_cnt <= '0;
                end else if (en)
                    r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised successor to the system clock divider.
- Keeps the free-running divide counter and the fast/slow CPU clock select.
- Adds glitch-free fast/slow switching and NCH independent runtime-programmable divider channels.
- Each channel produces a near-50% divided waveform and a one-cycle clock-enable tick.
- Sits at the top level beside the clock source; feeds the CPU clock, the display-scan and peripheral timing logic, and the UART baud tick.

Parameters:
- CNT_W, 32, width of the free-running counter clkdiv.
- FAST_BIT, 2, clkdiv bit used as the fast CPU clock.
- SLOW_BIT, 16, clkdiv bit used as the slow CPU clock. Must be greater than FAST_BIT and less than CNT_W.
- NCH, 2, number of programmable divider channels.
- DIV_W, 16, divisor width per channel.
- DEF_DIV, 16'd50, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sel_slow  in  1  1 selects the slow CPU clock. Asynchronous to clk (board switch).
- en  in  1  channel enable. Gates all channel counters; clkdiv is unaffected.
- div_load  in  NCH  per-channel load strobe.
- div_val  in  NCH*DIV_W  divisor data; channel i uses bits [i*DIV_W +: DIV_W].
- clkdiv  out  CNT_W  free-running counter.
- clk_cpu  out  1  registered, glitch-free CPU clock.
- ch_out  out  NCH  divided waveform per channel.
- ch_tick  out  NCH  one-cycle enable pulse per channel period.

Behaviour:
Reset (rst low, asynchronous):
- clkdiv=0, clk_cpu=0.
- Synchroniser flops=0, active_sel=0 (fast).
- All channel counters cnt=0; shadow and active divisors = DEF_DIV.
- ch_out and ch_tick follow their definitions below, so at reset ch_out=1 for DEF_DIV≥1 and ch_tick=0.

Free-running counter:
- clkdiv increments by 1 every cycle and wraps from all-ones to 0.

CPU clock:
- sel_slow passes through a 2-flop synchroniser to give sel_sync.
- active_sel loads sel_sync only on the cycle where clkdiv[SLOW_BIT:0] is all-ones. On the next cycle both selected bits are 0, so no runt pulse can occur.
- clk_cpu <= (clkdiv+1)[active_sel ? SLOW_BIT : FAST_BIT]. This is registered and matches the counter bit in phase.
- Switch latency from a sel_slow edge: 2 cycles of synchronisation, plus up to 2^(SLOW_BIT+1) cycles to reach the boundary.

Channel i (active divisor D, counter cnt):
- D=0: channel stopped. cnt holds 0, ch_out=0, ch_tick=0.
- D≥1 and en=1: cnt counts 0..D-1 and wraps to 0.
- en=0: cnt holds.
- ch_tick = en & (D≠0) & (cnt==D-1). For D=1 this is high on every enabled cycle.
- ch_out = (D≠0) & (cnt < ceil(D/2)). Period is D enabled cycles with ceil(D/2) high. D=1 gives a constant 1.
- ch_out and ch_tick are decoded from flops only and are for use as data or enables, never as clocks.

Divisor load:
- div_load[i]=1 writes the div_val slice into the shadow register.
- shadow→active transfer happens:
  - at the end of a ch_tick cycle (period boundary), with cnt→0, or
  - on the cycle after the shadow write, if the active D=0, with cnt=0.
- If a load and a tick occur in the same cycle, the newly loaded value becomes active at that boundary.
- Loading while en=0 takes effect at the next tick once en returns, or immediately if D=0.
- Loading 0 stops the channel at the next boundary.
- Multiple loads before a boundary: last write wins.

Reset mid-operation:
- Everything returns to reset values immediately.
- clk_cpu drops to 0 asynchronously; this is acceptable.

Test Plan:
1. Reset release, sel_slow=0, run 64 cycles → clkdiv=64; clk_cpu toggles every 4 cycles, equal to clkdiv[2] delayed 0 cycles in value.
2. Set sel_slow=1 at clkdiv=100 → clk_cpu keeps fast pattern until clkdiv wraps bits[16:0] at 131071→131072. After that it equals clkdiv[16]. No high or low pulse shorter than 4 cycles occurs anywhere (checker).
3. Channel 0: en=1, load D=5 at reset+10 → old D=50 period completes; then ch_tick every 5 cycles, ch_out pattern 1,1,1,0,0.
4. Load D=4 on the same cycle as a ch_tick → next period is 4 cycles. ch_out pattern 1,1,0,0.
5. Load D=0, then D=3 after 20 cycles → channel stops at next boundary (ch_out=0, tick=0). Restarts with cnt=0 on the cycle after the D=3 write; first tick arrives 3 cycles later.
6. Hold en=0 for 7 cycles mid-period, then assert rst low for 1 cycle mid-count → counter frozen during en=0 with no ticks. Reset clears clkdiv, cnt and clk_cpu and restores D=50 on both channels.
